// File: rtl/md5_loader.sv
// md5_loader: pads a short candidate message into a single MD5 block, streams
// it word by word into an MD5 unit and compares the returned digest with a target.
module md5_loader (
  input  logic         clk,
  input  logic         reset,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [439:0] msg_data,
  input  logic [5:0]   msg_len,
  input  logic [127:0] target,
  output logic         md5_write,
  output logic [3:0]   md5_writeaddr,
  output logic [31:0]  md5_writedata,
  output logic         md5_start,
  input  logic         md5_done,
  input  logic [127:0] md5_digest,
  output logic         result_valid,
  output logic         match,
  output logic         len_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    WAIT  = 3'd4,
    CMP   = 3'd5
  } state_t;

  state_t         state_r, next_state_s;
  logic [439:0]   data_r;
  logic [5:0]     len_r;
  logic [127:0]   target_r;
  logic [3:0]     cnt_r;
  logic           msg_ready_r, md5_write_r, md5_start_r, result_valid_r;
  logic           match_r, len_err_r;
  logic [3:0]     writeaddr_r;
  logic [31:0]    writedata_r;

  logic           handshake_s, len_bad_s;
  logic [3:0]     next_cnt_s;
  logic [439:0]   src_data_s;
  logic [5:0]     src_len_s;
  logic           next_match_s, next_len_err_s;

  // Padded block word idx: message bytes, 0x80 terminator, zeros, byte length in word 15.
  function automatic logic [31:0] pad_word(input logic [439:0] data,
                                           input logic [5:0]   len,
                                           input logic [3:0]   idx);
    logic [447:0] shifted;
    logic [7:0]   b [4];
    logic [5:0]   pos;
    logic [31:0]  word;
    for (int k = 0; k < 4; k++) begin
      b[k] = 8'h00;
    end
    if (idx == 4'd15) begin
      word = {26'd0, len};
    end else if (idx == 4'd14) begin
      word = 32'h0000_0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        pos     = {idx, 2'b00} + k[5:0];
        shifted = {8'h00, data} >> {pos, 3'b000};
        if (pos < len) begin
          b[k] = shifted[7:0];
        end else if (pos == len) begin
          b[k] = 8'h80;
        end else begin
          b[k] = 8'h00;
        end
      end
      word = {b[3], b[2], b[1], b[0]};
    end
    return word;
  endfunction

  assign handshake_s = msg_valid & msg_ready_r;
  assign len_bad_s   = (msg_len > 6'd55);

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          if (len_bad_s) begin
            next_state_s = CMP;
          end else begin
            next_state_s = LOAD;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (cnt_r == 4'd15) begin
          next_state_s = START;
        end else begin
          next_state_s = LOAD;
        end
      end
      START: next_state_s = BUSY;
      // A done left high by the previous run must fall before completion is accepted.
      BUSY: begin
        if (!md5_done) begin
          next_state_s = WAIT;
        end else begin
          next_state_s = BUSY;
        end
      end
      WAIT: begin
        if (md5_done) begin
          next_state_s = CMP;
        end else begin
          next_state_s = WAIT;
        end
      end
      CMP:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Word index, data source and result values feeding the output registers
  always_comb begin
    next_cnt_s     = 4'd0;
    src_data_s     = data_r;
    src_len_s      = len_r;
    next_match_s   = 1'b0;
    next_len_err_s = 1'b0;
    if (state_r == LOAD) begin
      next_cnt_s = cnt_r + 4'd1;
    end else begin
      next_cnt_s = 4'd0;
    end
    if (state_r == IDLE) begin
      src_data_s     = msg_data;
      src_len_s      = msg_len;
      next_len_err_s = 1'b1;
    end else begin
      src_data_s     = data_r;
      src_len_s      = len_r;
      next_len_err_s = 1'b0;
    end
    if (state_r == WAIT) begin
      next_match_s = (md5_digest == target_r);
    end else begin
      next_match_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Candidate capture at handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r   <= 440'd0;
      len_r    <= 6'd0;
      target_r <= 128'd0;
    end else if (handshake_s) begin
      data_r   <= msg_data;
      len_r    <= msg_len;
      target_r <= target;
    end
  end

  // Block write bus; idle values are forced to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= 4'd0;
      md5_write_r <= 1'b0;
      writeaddr_r <= 4'd0;
      writedata_r <= 32'd0;
    end else if (next_state_s == LOAD) begin
      cnt_r       <= next_cnt_s;
      md5_write_r <= 1'b1;
      writeaddr_r <= next_cnt_s;
      writedata_r <= pad_word(src_data_s, src_len_s, next_cnt_s);
    end else begin
      cnt_r       <= 4'd0;
      md5_write_r <= 1'b0;
      writeaddr_r <= 4'd0;
      writedata_r <= 32'd0;
    end
  end

  // Handshake, start and result outputs; match/len_err change only on entry to CMP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_ready_r    <= 1'b0;
      md5_start_r    <= 1'b0;
      result_valid_r <= 1'b0;
      match_r        <= 1'b0;
      len_err_r      <= 1'b0;
    end else begin
      msg_ready_r    <= (next_state_s == IDLE);
      md5_start_r    <= (next_state_s == START);
      result_valid_r <= (next_state_s == CMP);
      if (next_state_s == CMP) begin
        match_r   <= next_match_s;
        len_err_r <= next_len_err_s;
      end
    end
  end

  assign msg_ready     = msg_ready_r;
  assign md5_write     = md5_write_r;
  assign md5_writeaddr = writeaddr_r;
  assign md5_writedata = writedata_r;
  assign md5_start     = md5_start_r;
  assign result_valid  = result_valid_r;
  assign match         = match_r;
  assign len_err       = len_err_r;

endmodule

// File: tb/tb_md5_loader.sv
// Scoreboard bench for md5_loader: expected block words and results are queued at
// issue time and checked by a monitor; a behavioural MD5 stand-in returns digests.
module tb_md5_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         msg_valid;
  logic         msg_ready;
  logic [439:0] msg_data;
  logic [5:0]   msg_len;
  logic [127:0] target;
  logic         md5_write;
  logic [3:0]   md5_writeaddr;
  logic [31:0]  md5_writedata;
  logic         md5_start;
  logic         md5_done;
  logic [127:0] md5_digest;
  logic         result_valid;
  logic         match;
  logic         len_err;

  md5_loader dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_len(msg_len), .target(target),
    .md5_write(md5_write), .md5_writeaddr(md5_writeaddr), .md5_writedata(md5_writedata),
    .md5_start(md5_start), .md5_done(md5_done), .md5_digest(md5_digest),
    .result_valid(result_valid), .match(match), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic m; logic le; } res_t;

  wr_t          wq[$];
  res_t         rq[$];
  logic [127:0] dq[$];
  int           checks = 0, errors = 0;
  int           cyc = 0, hs_cyc = 0, start_cnt = 0, exp_starts = 0;
  int           hold_cfg = -1;

  localparam logic [127:0] T34 = 128'hbaebddf861d3eb2714ba892c2ad26682;
  logic [7:0]  m33 [42] = '{8'h08, 8'h02, 8'h68, 8'h01, 8'hbb, 8'h80, 8'hab, 8'h13, 8'h30, 8'h2c,
                            8'h8b, 8'hcb, 8'h82, 8'h75, 8'h65, 8'hb9, 8'h48, 8'h3c, 8'h79, 8'ha3,
                            8'hbe, 8'h26, 8'h3f, 8'h10, 8'hc4, 8'hda, 8'h78, 8'h0b, 8'h48, 8'h33,
                            8'h43, 8'h5c, 8'h87, 8'h92, 8'he9, 8'h4d, 8'h7c, 8'hbe, 8'hf0, 8'hef,
                            8'h33, 8'h85};
  logic [31:0] exp33 [16] = '{32'h01680208, 32'h13ab80bb, 32'hcb8b2c30, 32'hb9657582,
                              32'ha3793c48, 32'h103f26be, 32'h0b78dac4, 32'h5c433348,
                              32'h4de99287, 32'heff0be7c, 32'h00808533, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0000002a};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  // Reference padding: a 64-byte block filled from the rules, then read as little-endian words.
  function automatic logic [31:0] ref_word(input logic [439:0] d, input int len, input int w);
    logic [7:0] blk [64];
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < len; i++) blk[i] = d[8*i +: 8];
    blk[len] = 8'h80;
    blk[60]  = 8'(len);
    return {blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
  endfunction

  function automatic logic [439:0] rand_data();
    logic [447:0] t;
    for (int k = 0; k < 14; k++) t[32*k +: 32] = $urandom();
    return t[439:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic issue(input logic [439:0] d, input logic [5:0] len, input logic [127:0] tgt,
                       input logic [127:0] dig, input bit use_const);
    wr_t  w;
    res_t r;
    int   n;
    if (len > 6'd55) begin
      r.m = 1'b0; r.le = 1'b1;
      rq.push_back(r);
    end else begin
      for (int i = 0; i < 16; i++) begin
        w.addr = i[3:0];
        w.data = use_const ? exp33[i] : ref_word(d, int'(len), i);
        wq.push_back(w);
      end
      dq.push_back(dig);
      r.m = (dig == tgt); r.le = 1'b0;
      rq.push_back(r);
      exp_starts++;
    end
    msg_data = d; msg_len = len; target = tgt; msg_valid = 1'b1;
    n = 0;
    while (!msg_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!msg_ready) fail_now("ready_timeout", "msg_ready still 0 after 50 cycles, required 1");
    @(posedge clk); #1;
    hs_cyc = cyc;
    msg_valid = 1'b0;
    msg_data  = rand_data();
    msg_len   = 6'($urandom());
    target    = rand128();
  endtask

  task automatic await_result();
    int n = 0;
    while (rq.size() != 0 && n < 3000) begin
      @(posedge clk); n++;
    end
    #1;
    if (rq.size() != 0) begin
      fail_now("result_timeout", "no result_valid within 3000 cycles, required one");
      wq.delete(); rq.delete(); dq.delete();
    end
  endtask

  // Behavioural MD5 unit: keeps stale done high for a while, drops it, then returns the digest.
  initial begin : md5_model
    logic [127:0] dig;
    int           hold;
    forever begin
      @(negedge clk);
      if (!reset && md5_start) begin
        dig  = (dq.size() != 0) ? dq.pop_front() : 128'd0;
        hold = (hold_cfg >= 0) ? hold_cfg : int'($urandom_range(0, 4));
        repeat (hold) @(negedge clk);
        md5_done = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        md5_digest = dig;
        md5_done   = 1'b1;
      end
    end
  end

  // Monitor: pops expected writes/results whenever the DUT presents them.
  initial begin : monitor
    wr_t  ew;
    res_t er;
    logic prev_w15 = 1'b0, dropped = 1'b0, held_m = 1'b0, held_le = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_w15 = 1'b0; held_m = 1'b0; held_le = 1'b0;
      end else begin
        if (md5_write) begin
          if (wq.size() == 0) begin
            fail_now("write_unexpected", $sformatf("write addr %0d data %h, required none",
                     md5_writeaddr, md5_writedata));
          end else begin
            ew = wq.pop_front();
            chk("writeaddr", md5_writeaddr, ew.addr);
            chk("writedata", md5_writedata, ew.data);
          end
        end else begin
          chk("idle_bus_zero", {md5_writeaddr, md5_writedata}, 128'd0);
        end
        if (md5_start) begin
          chk("start_after_word15", prev_w15, 1'b1);
          start_cnt++;
          dropped = 1'b0;
        end
        if (!md5_done) dropped = 1'b1;
        chk("ready_only_idle", msg_ready & (md5_write | md5_start | result_valid), 1'b0);
        if (result_valid) begin
          if (rq.size() == 0) begin
            fail_now("result_unexpected", "result_valid=1, required 0");
          end else begin
            er = rq.pop_front();
            chk("match", match, er.m);
            chk("len_err", len_err, er.le);
            if (er.le) begin
              chk("len_err_latency", cyc - hs_cyc, 1);
            end else begin
              chk("min_latency_ge19", (cyc - hs_cyc) >= 19, 1'b1);
              chk("done_dropped_first", dropped, 1'b1);
            end
            held_m = er.m; held_le = er.le;
          end
        end else begin
          chk("match_hold", match, held_m);
          chk("len_err_hold", len_err, held_le);
        end
        prev_w15 = md5_write && (md5_writeaddr == 4'd15);
      end
    end
  end

  initial begin : stimulus
    logic [439:0] d;
    logic [127:0] tg;
    int           n;
    reset = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_len = 6'd0; target = '0;
    md5_done = 1'b1; md5_digest = 128'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", msg_ready, 1'b0);
    chk("reset_outputs", {md5_write, md5_writeaddr, md5_writedata, md5_start,
                          result_valid, match, len_err}, 128'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", msg_ready, 1'b1);

    d = '0;
    for (int i = 0; i < 42; i++) d[8*i +: 8] = m33[i];
    issue(d, 6'd42, T34, T34, 1'b1);            await_result();
    issue(d, 6'd42, T34 ^ 128'd1, T34, 1'b0);   await_result();
    issue(rand_data(), 6'd0, T34, T34, 1'b0);   await_result();
    tg = rand128();
    issue(rand_data(), 6'd55, tg, tg, 1'b0);    await_result();
    issue(rand_data(), 6'd56, tg, tg, 1'b0);    await_result();
    issue(rand_data(), 6'd63, tg, tg, 1'b0);    await_result();
    hold_cfg = 8;
    issue(rand_data(), 6'd17, tg, tg, 1'b0);    await_result();
    hold_cfg = -1;

    // Reset in the middle of the block load
    issue(rand_data(), 6'd30, tg, tg, 1'b0);
    n = 0;
    while (!(md5_write && md5_writeaddr == 4'd7) && n < 40) begin
      @(negedge clk); n++;
    end
    if (n >= 40) fail_now("addr7_timeout", "writeaddr 7 not seen, required within 40 cycles");
    #2 reset = 1'b1;
    #1;
    chk("midload_reset_outputs", {msg_ready, md5_write, md5_writeaddr, md5_writedata,
                                  md5_start, result_valid, match, len_err}, 128'd0);
    wq.delete(); rq.delete(); dq.delete();
    exp_starts--;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_midload_reset", msg_ready, 1'b1);
    issue(rand_data(), 6'd30, tg, tg ^ 128'h8000, 1'b0); await_result();

    for (int it = 0; it < 25; it++) begin
      tg = rand128();
      issue(rand_data(), 6'($urandom_range(0, 63)), tg,
            ($urandom_range(0, 1) == 1) ? tg : tg ^ (128'd1 << $urandom_range(0, 127)), 1'b0);
      await_result();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("start_count", start_cnt, exp_starts);
    chk("writes_drained", wq.size(), 0);
    chk("results_drained", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_loader.md
MD5_LOADER -- requirements
Module: md5_loader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port msg_valid, input, 1, candidate message offered.
REQ-004 SHALL have port msg_ready, output, 1, loader idle and able to accept a candidate.
REQ-005 SHALL have port msg_data, input, 440, candidate bytes; byte i on bits [8i+7:8i].
REQ-006 SHALL have port msg_len, input, 6, candidate length in bytes.
REQ-007 SHALL have port target, input, 128, digest to match; sampled at handshake.
REQ-008 SHALL have port md5_write, output, 1, word write strobe to the MD5 unit.
REQ-009 SHALL have port md5_writeaddr, output, 4, word index 0-15.
REQ-010 SHALL have port md5_writedata, output, 32, padded block word.
REQ-011 SHALL have port md5_start, output, 1, one-cycle start pulse to the MD5 unit.
REQ-012 SHALL have port md5_done, input, 1, MD5 unit finished.
REQ-013 SHALL have port md5_digest, input, 128, MD5 unit digest; valid while md5_done=1.
REQ-014 SHALL have port result_valid, output, 1, one-cycle result pulse.
REQ-015 SHALL have port match, output, 1, digest equals target; qualified by result_valid.
REQ-016 SHALL have port len_err, output, 1, msg_len > 55; qualified by result_valid.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> START -> BUSY -> WAIT -> CMP -> IDLE.
REQ-018 SHALL assert msg_ready only in IDLE; handshake = msg_valid & msg_ready; msg_data, msg_len, target captured into registers at handshake.
REQ-019 SHALL, on handshake with msg_len > 55, go to CMP with no MD5 writes; result_valid=1, len_err=1, match=0 one cycle after handshake.
REQ-020 SHALL build a padded block: bytes 0..len-1 = message; byte len = 8'h80; bytes len+1..59 = 0; word 15 = {26'b0, msg_len}; word 14 = 0.
REQ-021 SHALL, in LOAD, drive md5_write=1 for exactly 16 consecutive cycles, md5_writeaddr 0,1,...,15, md5_writedata = padded word at that index; first write in the cycle after the handshake.
REQ-022 SHALL assert md5_start for exactly one cycle (START), the cycle after writeaddr 15; md5_write=0 in START.
REQ-023 SHALL, in BUSY, wait until md5_done=0, then in WAIT until md5_done=1; stale done from a prior run is never taken as completion.
REQ-024 SHALL, in the cycle md5_done is seen high in WAIT, register match = (md5_digest == target) and go to CMP.
REQ-025 SHALL, in CMP, pulse result_valid for one cycle, then return to IDLE (msg_ready=1 next cycle).
REQ-026 SHALL hold match and len_err stable from CMP until the next CMP.
REQ-027 SHALL ignore msg_valid and changes to msg_data/msg_len/target outside IDLE.
REQ-028 SHALL have a minimum handshake-to-result_valid latency of 19 cycles plus MD5 unit time, and wait indefinitely on md5_done.
REQ-029 SHALL keep md5_writeaddr and md5_writedata at 0 whenever md5_write=0.

Reset
REQ-030 SHALL, on reset assertion at any time including mid-LOAD or WAIT, force IDLE and drive msg_ready=0 during reset; md5_write=0, md5_start=0, md5_writeaddr=0, md5_writedata=0, result_valid=0, match=0, len_err=0.
REQ-031 SHALL assert msg_ready the first cycle after reset deasserts.
REQ-032 SHALL NOT issue md5_start for any block interrupted by reset; the next candidate restarts at word 0.

Verification
REQ-033 42-byte message 08 02 68 01 bb 80 ab 13 30 2c 8b cb 82 75 65 b9 48 3c 79 a3 be 26 3f 10 c4 da 78 0b 48 33 43 5c 87 92 e9 4d 7c be f0 ef 33 85 -> words 0..15 = 01680208, 13ab80bb, cb8b2c30, b9657582, a3793c48, 103f26be, 0b78dac4, 5c433348, 4de99287, eff0be7c, 00808533, 0, 0, 0, 0, 0000002a.
REQ-034 Same message, target = baebddf861d3eb2714ba892c2ad26682, MD5 model returns that digest -> single result_valid pulse, match=1, len_err=0.
REQ-035 Same message, target differs in bit 0 -> match=0; msg_len=0 -> word 0 = 00000080, word 15 = 0.
REQ-036 msg_len=55 -> byte 55 = 80, word 13 = 80xxxxxx, word 15 = 00000037; msg_len=56 -> no md5_write, result_valid one cycle after handshake with len_err=1.
REQ-037 md5_done held high from a prior run through START -> no result until done drops and rises again.
REQ-038 Reset asserted at writeaddr 7 -> outputs zero immediately, no md5_start; next candidate writes words 0..15 in full.
